fifo_burst_reader: RTL and testbench

Read-side controller for the synchronous FIFO. On a start command it drains exactly `i_len` words from the FIFO read port and presents them on a valid/ready stream interface. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so it sustains one word per cycle with full backpressure support. It pairs with the FIFO's write side: the writer fills the FIFO, and this block is the consumer that empties it.

---
 rtl/fifo_burst_reader.sv | 133 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a synchronous FIFO. A start command drains
//   exactly i_len words from the FIFO read port and presents them on a
//   valid/ready stream. A 2-entry skid buffer absorbs the FIFO's one-cycle
//   read latency so the stream sustains one word per cycle under full
//   backpressure.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start, i_len        burst request and length, sampled only when idle
//   o_busy, o_done        burst in progress / one-cycle completion pulse
//   i_fifo_empty          FIFO empty flag
//   i_fifo_data           FIFO read data, valid the cycle after a read
//   o_fifo_rd_en          FIFO read enable (combinational)
//   o_valid, o_data       stream word out
//   i_ready               downstream accept
module fifo_burst_reader #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_busy,
   output logic             o_done,
   input  logic             i_fifo_empty,
   input  logic [WIDTH-1:0] i_fifo_data,
   output logic             o_fifo_rd_en,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] accepted;
   logic             vld_p1;
   logic [WIDTH-1:0] skid_mem [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       buf_cnt;
   logic             pop;
   logic [2:0]       credit;

   assign o_valid = (buf_cnt != 2'd0);
   assign o_data  = skid_mem[rd_ptr];
   assign o_busy  = (state != IDLE);
   assign o_done  = (state == DONE);
   assign pop     = o_valid && i_ready;

   // Buffer occupancy after the coming edge; a read issued now lands one
   // edge later, so it needs this to be below 2.
   assign credit = {1'b0, buf_cnt} + {2'b00, vld_p1} - {2'b00, pop};

   always_comb begin
      state_nxt    = state;
      o_fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = (i_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            o_fifo_rd_en = !i_fifo_empty && (issued < len_q) && (credit < 3'd2);
            if ((o_fifo_rd_en && (issued + CNT_ONE == len_q)) || (issued == len_q)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge of the final handshake so o_done follows it.
            if ((pop && (accepted + CNT_ONE == len_q)) || (accepted == len_q)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         len_q       <= '0;
         issued      <= '0;
         accepted    <= '0;
         vld_p1      <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         buf_cnt     <= 2'd0;
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
      end else begin
         state <= state_nxt;

         if ((state == IDLE) && i_start) begin
            len_q    <= i_len;
            issued   <= '0;
            accepted <= '0;
         end else begin
            if (o_fifo_rd_en) issued <= issued + CNT_ONE;
            if (pop) accepted <= accepted + CNT_ONE;
         end

         // p0 -> p1: read accepted by the FIFO, data appears next cycle
         vld_p1 <= o_fifo_rd_en;

         // p1 -> skid buffer: capture the FIFO word as it appears
         if (vld_p1) begin
            skid_mem[wr_ptr] <= i_fifo_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({vld_p1, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [7:0]  i_len = '0;
   logic        o_busy, o_done;
   logic        fifo_empty;
   logic [31:0] fifo_q = '0;
   logic        o_fifo_rd_en;
   logic        o_valid;
   logic [31:0] o_data;
   logic        i_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   fifo_burst_reader #(.WIDTH(32), .CNT_W(8)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_len        (i_len),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .i_fifo_empty (fifo_empty),
      .i_fifo_data  (fifo_q),
      .o_fifo_rd_en (o_fifo_rd_en),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .i_ready      (i_ready)
   );

   always #5 i_clk = ~i_clk;

   // FIFO model: registered read data, not affected by the reader's reset.
   logic [31:0] fmem [0:255];
   int wptr = 0;
   int rptr = 0;
   int rd_empty_viol = 0;
   assign fifo_empty = (wptr == rptr);

   always @(posedge i_clk) begin
      if (o_fifo_rd_en) begin
         if (fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
         else begin
            fifo_q <= fmem[rptr];
            rptr   <= rptr + 1;
         end
      end
   end

   task automatic push_word(input logic [31:0] v);
      fmem[wptr] = v;
      wptr = wptr + 1;
   endtask

   // Observations from the most recent burst
   logic [31:0] out_q [$];
   int          out_cyc [$];
   int n_rd, n_done, first_valid, done_cyc, n_out_at_done;
   int stall_bad, max_out, busy_bad, rst_hit;
   logic snap_valid, snap_busy, snap_done, snap_rd;
   logic [31:0] snap_data;

   task automatic run_burst(input logic [7:0] len, input int ready_mode,
                            input int push_cyc, input int push_n, input logic [31:0] push_base,
                            input int restart_cyc, input int rst_after, input int budget);
      int iss, pops;
      logic stall_pend;
      logic [31:0] stall_data;
      out_q.delete();
      out_cyc.delete();
      n_rd = 0; n_done = 0; first_valid = -1; done_cyc = -1; n_out_at_done = -1;
      stall_bad = 0; max_out = 0; busy_bad = 0; rst_hit = 0;
      iss = 0; pops = 0; stall_pend = 1'b0; stall_data = '0;
      i_start = 1'b1;
      i_len   = len;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_len   = '0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         i_ready = (ready_mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (cyc == push_cyc) begin
            for (int k = 0; k < push_n; k++) push_word(push_base + 32'(k));
         end
         if (cyc == restart_cyc) begin
            i_start = 1'b1;
            i_len   = 8'd5;
         end else begin
            i_start = 1'b0;
            i_len   = '0;
         end
         @(negedge i_clk);
         if (iss - pops > max_out) max_out = iss - pops;
         if (stall_pend && (!o_valid || o_data !== stall_data)) stall_bad++;
         stall_pend = 1'b0;
         if (o_valid && !i_ready) begin
            stall_pend = 1'b1;
            stall_data = o_data;
         end
         if (o_fifo_rd_en) begin
            n_rd++;
            iss++;
         end
         if (o_valid && first_valid < 0) first_valid = cyc;
         if (o_valid && i_ready) begin
            out_q.push_back(o_data);
            out_cyc.push_back(cyc);
            pops++;
         end
         if (!o_busy && n_done == 0) busy_bad++;
         if (o_done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               n_out_at_done = out_q.size();
            end
         end
         if (rst_after > 0 && pops == rst_after) begin
            @(posedge i_clk);
            #1 i_rst = 1'b1;
            #1;
            snap_valid = o_valid;
            snap_busy  = o_busy;
            snap_done  = o_done;
            snap_rd    = o_fifo_rd_en;
            snap_data  = o_data;
            @(posedge i_clk);
            #1 i_rst = 1'b0;
            rst_hit = 1;
            break;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         @(posedge i_clk);
         #1;
      end
      i_start = 1'b0;
      i_ready = 1'b1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", o_done); end
      checks++; if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", o_fifo_rd_en); end
      checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", o_data); end
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", o_busy); end
   endtask

   task automatic test_basic;
      logic [31:0] got;
      for (int k = 1; k <= 10; k++) push_word(32'(k));
      run_burst(8'd10, 0, -1, 0, 32'h0, -1, 0, 60);
      checks++; if (out_q.size() != 10) begin errors++; $display("FAIL basic_count got %0d want 10", out_q.size()); end
      for (int i = 0; i < 10; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 32'hDEAD_DEAD;
         checks++; if (got !== 32'(i + 1)) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got, 32'(i + 1)); end
      end
      checks++; if (n_rd != 10) begin errors++; $display("FAIL basic_reads got %0d want 10", n_rd); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", n_done); end
      checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_valid); end
      checks++; if (out_cyc.size() != 10 || out_cyc[out_cyc.size() - 1] != 11) begin
         errors++; $display("FAIL basic_last_hs got %0d want 11", (out_cyc.size() > 0) ? out_cyc[out_cyc.size() - 1] : -1); end
      checks++; if (done_cyc != 12) begin errors++; $display("FAIL basic_done_cyc got %0d want 12", done_cyc); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy got %0d low cycles want 0", busy_bad); end
   endtask

   task automatic test_backpressure;
      logic [31:0] got;
      for (int k = 0; k < 8; k++) push_word(32'hB000_0000 + 32'(k));
      run_burst(8'd8, 1, -1, 0, 32'h0, -1, 0, 200);
      checks++; if (out_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", out_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 32'hDEAD_DEAD;
         checks++; if (got !== 32'hB000_0000 + 32'(i)) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got, 32'hB000_0000 + 32'(i)); end
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", stall_bad); end
      checks++; if (max_out > 2) begin errors++; $display("FAIL bp_occupancy got %0d want <=2", max_out); end
      checks++; if (n_rd != 8) begin errors++; $display("FAIL bp_reads got %0d want 8", n_rd); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", n_done); end
   endtask

   task automatic test_underflow;
      logic [31:0] got;
      for (int k = 1; k <= 3; k++) push_word(32'hC0 + 32'(k));
      run_burst(8'd6, 0, 20, 3, 32'hC4, -1, 0, 100);
      checks++; if (out_q.size() != 6) begin errors++; $display("FAIL uf_count got %0d want 6", out_q.size()); end
      for (int i = 0; i < 6; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 32'hDEAD_DEAD;
         checks++; if (got !== 32'hC1 + 32'(i)) begin errors++; $display("FAIL uf_word%0d got %h want %h", i, got, 32'hC1 + 32'(i)); end
      end
      checks++; if (out_cyc.size() < 4 || out_cyc[2] != 4 || out_cyc[3] != 22) begin
         errors++; $display("FAIL uf_resume got %0d want 22", (out_cyc.size() > 3) ? out_cyc[3] : -1); end
      checks++; if (done_cyc != 25) begin errors++; $display("FAIL uf_done_cyc got %0d want 25", done_cyc); end
      checks++; if (n_out_at_done != 6) begin errors++; $display("FAIL uf_done_after got %0d words want 6", n_out_at_done); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL uf_done_count got %0d want 1", n_done); end
      checks++; if (n_rd != 6) begin errors++; $display("FAIL uf_reads got %0d want 6", n_rd); end
      checks++; if (rd_empty_viol != 0) begin errors++; $display("FAIL uf_rd_while_empty got %0d want 0", rd_empty_viol); end
   endtask

   task automatic test_zero_len;
      push_word(32'hF1);
      run_burst(8'd0, 0, -1, 0, 32'h0, -1, 0, 20);
      checks++; if (n_rd != 0) begin errors++; $display("FAIL zl_reads got %0d want 0", n_rd); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL zl_done_count got %0d want 1", n_done); end
      checks++; if (done_cyc != 0) begin errors++; $display("FAIL zl_done_cyc got %0d want 0", done_cyc); end
      checks++; if (first_valid != -1) begin errors++; $display("FAIL zl_valid got first at %0d want never", first_valid); end
      run_burst(8'd1, 0, -1, 0, 32'h0, -1, 0, 20);
      checks++; if (out_q.size() != 1 || out_q[0] !== 32'hF1) begin
         errors++; $display("FAIL zl_next_word got %h want f1", (out_q.size() > 0) ? out_q[0] : 32'hDEAD_DEAD); end
      checks++; if (done_cyc != 3) begin errors++; $display("FAIL len1_done_cyc got %0d want 3", done_cyc); end
   endtask

   task automatic test_start_busy;
      logic [31:0] got;
      for (int k = 1; k <= 10; k++) push_word(32'hD00 + 32'(k));
      run_burst(8'd10, 0, -1, 0, 32'h0, 4, 0, 60);
      checks++; if (out_q.size() != 10) begin errors++; $display("FAIL sb_count got %0d want 10", out_q.size()); end
      for (int i = 0; i < 10; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 32'hDEAD_DEAD;
         checks++; if (got !== 32'hD01 + 32'(i)) begin errors++; $display("FAIL sb_word%0d got %h want %h", i, got, 32'hD01 + 32'(i)); end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL sb_done_count got %0d want 1", n_done); end
      checks++; if (n_rd != 10) begin errors++; $display("FAIL sb_reads got %0d want 10", n_rd); end
      checks++; if (done_cyc != 12) begin errors++; $display("FAIL sb_done_cyc got %0d want 12", done_cyc); end
   endtask

   task automatic test_reset_mid;
      for (int k = 1; k <= 10; k++) push_word(32'hE00 + 32'(k));
      run_burst(8'd10, 0, -1, 0, 32'h0, -1, 4, 60);
      checks++; if (rst_hit != 1) begin errors++; $display("FAIL rm_reached got %0d want 1", rst_hit); end
      checks++; if (out_q.size() != 4 || out_q[3] !== 32'hE04) begin
         errors++; $display("FAIL rm_pre_words got %0d words want 4", out_q.size()); end
      checks++; if ({snap_valid, snap_busy, snap_done, snap_rd} !== 4'b0000) begin
         errors++; $display("FAIL rm_outputs got v%b b%b d%b r%b want all 0", snap_valid, snap_busy, snap_done, snap_rd); end
      checks++; if (snap_data !== 32'h0) begin errors++; $display("FAIL rm_data got %h want 0", snap_data); end
      // Six reads were issued before reset (two words discarded), so the FIFO head is E07.
      run_burst(8'd2, 0, -1, 0, 32'h0, -1, 0, 30);
      checks++; if (out_q.size() != 2) begin errors++; $display("FAIL rm_post_count got %0d want 2", out_q.size()); end
      checks++; if (out_q.size() < 1 || out_q[0] !== 32'hE07) begin
         errors++; $display("FAIL rm_post_word0 got %h want e07", (out_q.size() > 0) ? out_q[0] : 32'hDEAD_DEAD); end
      checks++; if (out_q.size() < 2 || out_q[1] !== 32'hE08) begin
         errors++; $display("FAIL rm_post_word1 got %h want e08", (out_q.size() > 1) ? out_q[1] : 32'hDEAD_DEAD); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL rm_post_done got %0d want 1", n_done); end
      checks++; if (n_rd != 2) begin errors++; $display("FAIL rm_post_reads got %0d want 2", n_rd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_underflow();
      test_zero_len();
      test_start_busy();
      test_reset_mid();
      checks++; if (rd_empty_viol != 0) begin errors++; $display("FAIL rd_while_empty got %0d want 0", rd_empty_viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
